fifo_unloader: RTL and testbench

Downstream drain stage for the FloPoCo-format result FIFO (MEM). After training completes, it reads exactly N_WORDS entries from the FIFO and presents each as an IEEE-754 single plus exception tag on a valid/ready stream to the weight-readout logic. It mirrors FIFO occupancy so it never reads an empty FIFO. It flags any inf/NaN entries seen.

---
 rtl/fifo_unloader_if.sv | 24 ++
 rtl/fifo_unloader.sv | 118 +++++++++++
 tb/tb_fifo_unloader.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_unloader_if.sv
// FIFO-side and output-stream signals of the result drain stage.
// master = the unloader, slave = the FIFO/readout side.
interface fifo_unloader_if #(
   parameter int W = 32
);
   logic          fifo_wr_en;
   logic          fifo_rd_en;
   logic [W+1:0]  fifo_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [1:0]    out_exc;
   logic [7:0]    out_index;

   modport master (
      input  fifo_wr_en, fifo_data, out_ready,
      output fifo_rd_en, out_valid, out_data, out_exc, out_index
   );

   modport slave (
      output fifo_wr_en, fifo_data, out_ready,
      input  fifo_rd_en, out_valid, out_data, out_exc, out_index
   );
endinterface

// File: rtl/fifo_unloader.sv
// Drains N_WORDS FloPoCo words from the result FIFO onto a valid/ready stream; read-to-valid 2 cycles.
// Backpressure: a 2-entry skid absorbs in-flight reads, so out_ready low only throttles fifo_rd_en.
module fifo_unloader #(
   parameter int W       = 32,
   parameter int ADDR    = 2,
   parameter int N_WORDS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   fifo_unloader_if.master  bus,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [1:0] {IDLE, DRAIN, WAIT, DONE} state_t;

   localparam logic [7:0]    N_TOTAL = 8'(N_WORDS);
   localparam logic [7:0]    N_LAST  = 8'(N_WORDS - 1);
   localparam logic [ADDR:0] OCC_MAX = {1'b1, {ADDR{1'b0}}};

   state_t        state, state_nxt;
   logic [ADDR:0] occ;
   logic [7:0]    issued;
   logic [7:0]    delivered;
   logic [W+1:0]  skid0;
   logic [W+1:0]  skid1;
   logic [1:0]    used;
   logic          inflight;
   logic          pop;
   logic          rd_en;
   logic          occ_inc;
   logic [2:0]    pending;

   assign bus.out_valid = (used != 2'd0);
   assign pop           = bus.out_valid && bus.out_ready;
   assign occ_inc       = bus.fifo_wr_en && (occ != OCC_MAX);
   assign pending       = {1'b0, used} + {2'b00, inflight};

   // A read may be issued only if the skid still has room once this cycle's pop leaves.
   assign rd_en = (state == DRAIN) && (occ != '0) && (issued < N_TOTAL) &&
                  (pending < (3'd2 + {2'b00, pop}));

   assign bus.fifo_rd_en = rd_en;
   assign bus.out_data   = skid0[W-1:0];
   assign bus.out_exc    = skid0[W+1:W];
   assign bus.out_index  = delivered;
   assign busy           = (state == DRAIN) || (state == WAIT);
   assign done           = (state == DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = DRAIN;
         DRAIN: begin
            if (pop && (delivered == N_LAST)) state_nxt = DONE;
            else if (issued == N_TOTAL)       state_nxt = WAIT;
         end
         WAIT:    if (pop && (delivered == N_LAST)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         occ       <= '0;
         issued    <= '0;
         delivered <= '0;
         err       <= 1'b0;
         skid0     <= '0;
         skid1     <= '0;
         used      <= 2'd0;
         inflight  <= 1'b0;
      end else begin
         state    <= state_nxt;
         occ      <= occ + {{ADDR{1'b0}}, occ_inc} - {{ADDR{1'b0}}, rd_en};
         inflight <= rd_en;

         if ((state == IDLE) && start) begin
            issued    <= '0;
            delivered <= '0;
            err       <= 1'b0;
         end else begin
            if (rd_en) issued <= issued + 8'd1;
            if (pop) begin
               delivered <= delivered + 8'd1;
               if (skid0[W+1]) err <= 1'b1;
            end
         end

         // Head is always skid0; returning read data lands behind whatever stays.
         case ({inflight, pop})
            2'b01: begin
               skid0 <= skid1;
               used  <= used - 2'd1;
            end
            2'b10: begin
               if (used == 2'd0) skid0 <= bus.fifo_data;
               else              skid1 <= bus.fifo_data;
               used <= used + 2'd1;
            end
            2'b11: begin
               if (used == 2'd2) begin
                  skid0 <= skid1;
                  skid1 <= bus.fifo_data;
               end else begin
                  skid0 <= bus.fifo_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_unloader.sv
// Directed bench for fifo_unloader with a behavioural depth-4 result FIFO.
module tb_fifo_unloader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, err;
   logic [33:0] wdata = '0;
   int          errors = 0;
   int          checks = 0;

   logic [33:0] mem_q [$];

   logic [33:0] pat_a [4] = '{{2'b01, 32'h3DCCCCCD}, {2'b01, 32'h3F800000},
                              {2'b01, 32'h3F800001}, {2'b01, 32'h3F800003}};
   logic [33:0] pat_n [4] = '{{2'b00, 32'h00000000}, {2'b01, 32'h40400000},
                              {2'b11, 32'h7FC00000}, {2'b01, 32'h40800000}};
   logic [33:0] pat_b [4] = '{{2'b01, 32'h3E800000}, {2'b01, 32'h3F000000},
                              {2'b01, 32'h3F400000}, {2'b01, 32'h3F800000}};

   fifo_unloader_if #(.W(32)) bus ();

   fifo_unloader #(.W(32), .ADDR(2), .N_WORDS(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bus   (bus),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   always #5 clk = ~clk;

   // Result FIFO: depth 4, write when full dropped, data one cycle after read.
   always @(posedge clk) begin
      if (rst) begin
         mem_q.delete();
         bus.fifo_data <= '0;
      end else begin
         if (bus.fifo_wr_en && mem_q.size() < 4) mem_q.push_back(wdata);
         if (bus.fifo_rd_en && mem_q.size() > 0) bus.fifo_data <= mem_q.pop_front();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      bus.fifo_wr_en = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic preload(input logic [33:0] p [4]);
      for (int i = 0; i < 4; i++) begin
         bus.fifo_wr_en = 1'b1;
         wdata = p[i];
         tick();
      end
      bus.fifo_wr_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.fifo_wr_en = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      @(negedge clk);
      checks++;
      if ({bus.fifo_rd_en, bus.out_valid, bus.out_data, bus.out_exc, bus.out_index,
           busy, done, err} !== 47'd0) begin
         errors++;
         $display("FAIL reset_outputs got rd=%b vld=%b dat=%h exc=%b idx=%0d busy=%b done=%b err=%b expected all 0",
                  bus.fifo_rd_en, bus.out_valid, bus.out_data, bus.out_exc, bus.out_index, busy, done, err);
      end
      checks++;
      if (dut.occ !== 3'd0) begin
         errors++;
         $display("FAIL reset_occ got %0d expected 0", dut.occ);
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int beats = 0;
      int dn = 0;
      do_reset();
      preload(pat_a);
      bus.out_ready = 1'b1;
      start = 1'b1;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (k == 1) begin
            checks++;
            if ({busy, bus.fifo_rd_en} !== 2'b11) begin
               errors++;
               $display("FAIL basic_first_read busy,rd_en=%b expected 11", {busy, bus.fifo_rd_en});
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (beats >= 4 || k != beats + 3 ||
                {bus.out_exc, bus.out_data, bus.out_index} !== {pat_a[beats], 8'(beats)}) begin
               errors++;
               $display("FAIL basic_beat%0d got exc=%b dat=%h idx=%0d at cycle %0d expected %h idx=%0d at cycle %0d",
                        beats, bus.out_exc, bus.out_data, bus.out_index, k, pat_a[beats & 3], beats, beats + 3);
            end
            beats++;
         end
         if (done) begin
            dn++;
            checks++;
            if (k != 7) begin
               errors++;
               $display("FAIL basic_done_cycle got %0d expected 7", k);
            end
         end
         tick();
         start = 1'b0;
      end
      checks++;
      if (beats != 4 || dn != 1 || err !== 1'b0) begin
         errors++;
         $display("FAIL basic_totals got beats=%0d done=%0d err=%b expected 4 1 0", beats, dn, err);
      end
   endtask

   task automatic test_backpressure();
      int beats = 0;
      int dn = 0;
      logic        stalled = 1'b0;
      logic [41:0] held = '0;
      do_reset();
      preload(pat_a);
      start = 1'b1;
      for (int k = 0; k < 40; k++) begin
         bus.out_ready = (k % 4 == 0) || (k % 4 == 3);
         @(negedge clk);
         checks++;
         if (({1'b0, dut.used} + {2'b00, dut.inflight}) > 3'd2) begin
            errors++;
            $display("FAIL bp_skid_room got used=%0d inflight=%0d expected sum <= 2", dut.used, dut.inflight);
         end
         if (stalled) begin
            checks++;
            if (bus.out_valid !== 1'b1 || {bus.out_exc, bus.out_data, bus.out_index} !== held) begin
               errors++;
               $display("FAIL bp_stall_hold got vld=%b word=%h expected vld=1 word=%h",
                        bus.out_valid, {bus.out_exc, bus.out_data, bus.out_index}, held);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (beats >= 4 || {bus.out_exc, bus.out_data, bus.out_index} !== {pat_a[beats], 8'(beats)}) begin
               errors++;
               $display("FAIL bp_beat%0d got exc=%b dat=%h idx=%0d expected %h idx=%0d",
                        beats, bus.out_exc, bus.out_data, bus.out_index, pat_a[beats & 3], beats);
            end
            beats++;
         end
         stalled = bus.out_valid && !bus.out_ready;
         held = {bus.out_exc, bus.out_data, bus.out_index};
         if (done) dn++;
         tick();
         start = 1'b0;
      end
      checks++;
      if (beats != 4 || dn != 1) begin
         errors++;
         $display("FAIL bp_totals got beats=%0d done=%0d expected 4 1", beats, dn);
      end
   endtask

   task automatic test_empty_start();
      int beats = 0;
      int dn = 0;
      int nw = 0;
      do_reset();
      bus.out_ready = 1'b1;
      start = 1'b1;
      for (int k = 0; k < 24; k++) begin
         if (k % 3 == 2 && nw < 4) begin
            bus.fifo_wr_en = 1'b1;
            wdata = pat_b[nw];
            nw++;
         end else begin
            bus.fifo_wr_en = 1'b0;
         end
         @(negedge clk);
         checks++;
         if (bus.fifo_rd_en && dut.occ == 3'd0) begin
            errors++;
            $display("FAIL empty_read_at_zero got rd_en=1 with occ=0 at cycle %0d expected rd_en=0", k);
         end
         if (k == 2 || k == 3) begin
            checks++;
            if (bus.fifo_rd_en !== (k == 3)) begin
               errors++;
               $display("FAIL empty_resume got rd_en=%b at cycle %0d expected %b", bus.fifo_rd_en, k, k == 3);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (beats >= 4 || {bus.out_exc, bus.out_data, bus.out_index} !== {pat_b[beats], 8'(beats)}) begin
               errors++;
               $display("FAIL empty_beat%0d got exc=%b dat=%h idx=%0d expected %h idx=%0d",
                        beats, bus.out_exc, bus.out_data, bus.out_index, pat_b[beats & 3], beats);
            end
            beats++;
         end
         if (done) dn++;
         tick();
         start = 1'b0;
      end
      bus.fifo_wr_en = 1'b0;
      checks++;
      if (beats != 4 || dn != 1) begin
         errors++;
         $display("FAIL empty_totals got beats=%0d done=%0d expected 4 1", beats, dn);
      end
   endtask

   task automatic test_nan();
      int beats = 0;
      int dn = 0;
      do_reset();
      preload(pat_n);
      bus.out_ready = 1'b1;
      start = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (beats >= 4 || {bus.out_exc, bus.out_data, bus.out_index} !== {pat_n[beats], 8'(beats)}) begin
               errors++;
               $display("FAIL nan_beat%0d got exc=%b dat=%h idx=%0d expected %h idx=%0d",
                        beats, bus.out_exc, bus.out_data, bus.out_index, pat_n[beats & 3], beats);
            end
            beats++;
         end
         if (k >= 3 && k <= 7) begin
            checks++;
            if (err !== (k >= 6)) begin
               errors++;
               $display("FAIL nan_err got %b at cycle %0d expected %b", err, k, k >= 6);
            end
         end
         if (done) dn++;
         tick();
         start = 1'b0;
      end
      preload(pat_b);
      @(negedge clk);
      checks++;
      if (beats != 4 || dn != 1 || err !== 1'b1) begin
         errors++;
         $display("FAIL nan_sticky got beats=%0d done=%0d err=%b expected 4 1 1", beats, dn, err);
      end
      tick();
      beats = 0;
      start = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k == 1) begin
            checks++;
            if (err !== 1'b0) begin
               errors++;
               $display("FAIL nan_err_clear got %b expected 0", err);
            end
         end
         if (bus.out_valid && bus.out_ready) beats++;
         tick();
         start = 1'b0;
      end
      checks++;
      if (beats != 4 || err !== 1'b0) begin
         errors++;
         $display("FAIL nan_second_drain got beats=%0d err=%b expected 4 0", beats, err);
      end
   endtask

   task automatic test_occ();
      do_reset();
      bus.fifo_wr_en = 1'b1;
      wdata = pat_a[0];
      tick();
      bus.fifo_wr_en = 1'b0;
      bus.out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      bus.fifo_wr_en = 1'b1;
      wdata = pat_a[1];
      @(negedge clk);
      checks++;
      if ({bus.fifo_rd_en, dut.occ} !== {1'b1, 3'd1}) begin
         errors++;
         $display("FAIL occ_pre_simul got rd_en=%b occ=%0d expected 1 1", bus.fifo_rd_en, dut.occ);
      end
      tick();
      bus.fifo_wr_en = 1'b0;
      @(negedge clk);
      checks++;
      if (dut.occ !== 3'd1) begin
         errors++;
         $display("FAIL occ_simul_rw got %0d expected 1", dut.occ);
      end
      do_reset();
      for (int i = 0; i < 5; i++) begin
         bus.fifo_wr_en = 1'b1;
         wdata = pat_b[i % 4];
         @(negedge clk);
         if (i == 4) begin
            checks++;
            if (dut.occ !== 3'd4) begin
               errors++;
               $display("FAIL occ_fill got %0d expected 4", dut.occ);
            end
         end
         tick();
      end
      bus.fifo_wr_en = 1'b0;
      @(negedge clk);
      checks++;
      if (dut.occ !== 3'd4) begin
         errors++;
         $display("FAIL occ_write_full got %0d expected 4", dut.occ);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int beats = 0;
      int dn = 0;
      do_reset();
      preload(pat_a);
      start = 1'b1;
      for (int k = 0; k < 7; k++) begin
         bus.out_ready = (k <= 3);
         rst = (k == 5);
         @(negedge clk);
         if (k == 4) begin
            checks++;
            if ({bus.out_valid, bus.out_index} !== {1'b1, 8'd1}) begin
               errors++;
               $display("FAIL mid_stalled got vld=%b idx=%0d expected 1 1", bus.out_valid, bus.out_index);
            end
         end
         if (k == 6) begin
            checks++;
            if ({bus.out_valid, busy, done, bus.fifo_rd_en, dut.occ} !== 7'd0) begin
               errors++;
               $display("FAIL mid_abort got vld=%b busy=%b done=%b rd=%b occ=%0d expected all 0",
                        bus.out_valid, busy, done, bus.fifo_rd_en, dut.occ);
            end
         end
         tick();
         start = 1'b0;
      end
      rst = 1'b0;
      preload(pat_b);
      bus.out_ready = 1'b1;
      start = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (beats >= 4 || {bus.out_exc, bus.out_data, bus.out_index} !== {pat_b[beats], 8'(beats)}) begin
               errors++;
               $display("FAIL mid_refill_beat%0d got exc=%b dat=%h idx=%0d expected %h idx=%0d",
                        beats, bus.out_exc, bus.out_data, bus.out_index, pat_b[beats & 3], beats);
            end
            beats++;
         end
         if (done) dn++;
         tick();
         start = 1'b0;
      end
      checks++;
      if (beats != 4 || dn != 1) begin
         errors++;
         $display("FAIL mid_refill_totals got beats=%0d done=%0d expected 4 1", beats, dn);
      end
   endtask

   initial begin
      bus.fifo_wr_en = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_empty_start();
      test_nan();
      test_occ();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
